// File: rtl/res_collector_if.sv
// ---------------------------------------------------------------------------
// res_collector_if
//
// Bundles the item-input handshake, the flush/acknowledge controls and the
// batch outputs of res_collector into one interface.
//
//   in_valid_i   : result item present on in_data_i
//   in_data_i    : result item from the compute stage (ITEM_WIDTH bits)
//   in_ready_o   : collector can accept an item this cycle
//   flush_i      : close the current partial batch early
//   batch_ack_i  : consumer has read the completed batch
//   batch_done_o : completed batch available
//   batch_data_o : packed batch, item k at [k*ITEM_WIDTH +: ITEM_WIDTH]
//   count_o      : number of items in the current batch
//   checksum_o   : 16-bit running sum of the batch (only with
//                  RES_COLLECTOR_CHECKSUM_EN defined)
//
// Modports:
//   master : the producer/consumer side driving items, flush and ack
//   slave  : the collector itself
// ---------------------------------------------------------------------------
interface res_collector_if #(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = 8
);
    localparam int CW = $clog2(NUM + 1);

    logic                      in_valid_i;
    logic [ITEM_WIDTH-1:0]     in_data_i;
    logic                      in_ready_o;
    logic                      flush_i;
    logic                      batch_ack_i;
    logic                      batch_done_o;
    logic [NUM*ITEM_WIDTH-1:0] batch_data_o;
    logic [CW-1:0]             count_o;
`ifdef RES_COLLECTOR_CHECKSUM_EN
    logic [15:0]               checksum_o;
`endif

    modport master (
        output in_valid_i,
        output in_data_i,
        output flush_i,
        output batch_ack_i,
        input  in_ready_o,
        input  batch_done_o,
        input  batch_data_o,
        input  count_o
`ifdef RES_COLLECTOR_CHECKSUM_EN
        ,
        input  checksum_o
`endif
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  flush_i,
        input  batch_ack_i,
        output in_ready_o,
        output batch_done_o,
        output batch_data_o,
        output count_o
`ifdef RES_COLLECTOR_CHECKSUM_EN
        ,
        output checksum_o
`endif
    );

endinterface

// File: rtl/res_collector.sv
// ---------------------------------------------------------------------------
// res_collector
//
// Collects NUM result items of ITEM_WIDTH bits into one packed batch. Items
// are written to consecutive slots while collecting; the batch is closed
// either when the last slot is filled or early by flush_i, and is then held
// (in_ready_o low, batch_done_o high) until the consumer acknowledges it.
//
// Ports:
//   clk_i   : single clock, all logic on the rising edge
//   reset_i : synchronous, active-high reset
//   bus     : res_collector_if.slave (item handshake, flush, ack, batch out)
//
// Optional feature:
//   RES_COLLECTOR_CHECKSUM_EN - when defined, adds bus.checksum_o, the
//   modulo-2^16 sum of all items accepted into the current batch.
// ---------------------------------------------------------------------------
module res_collector #(
    parameter int NUM        = 100,
    parameter int ITEM_WIDTH = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    res_collector_if.slave bus
);

    localparam int            CW        = $clog2(NUM + 1);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t                    state_q;
    state_t                    state_d;
    logic [CW-1:0]             count_q;
    logic [NUM*ITEM_WIDTH-1:0] batch_data_q;
    logic                      accept;
    logic                      ack_batch;
`ifdef RES_COLLECTOR_CHECKSUM_EN
    logic [15:0]               checksum_q;
`endif

    // Next-state and handshake outputs. Outputs depend only on the state,
    // so the consumer sees batch_done_o one cycle after the closing edge.
    always_comb begin
        state_d          = state_q;
        accept           = 1'b0;
        ack_batch        = 1'b0;
        bus.in_ready_o   = 1'b0;
        bus.batch_done_o = 1'b0;

        case (state_q)
            COLLECT: begin
                bus.in_ready_o = 1'b1;
                accept         = bus.in_valid_i;
                // Filling the last slot closes the batch; a flush closes it
                // only if it holds something, counting an item taken now.
                if (accept && (count_q == LAST_SLOT)) begin
                    state_d = FULL;
                end else if (bus.flush_i && ((count_q != '0) || accept)) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                bus.batch_done_o = 1'b1;
                ack_batch        = bus.batch_ack_i;
                if (bus.batch_ack_i) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot storage and item count. Slots are not cleared on acknowledge:
    // the previous batch stays visible until new items overwrite it.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q      <= '0;
            batch_data_q <= '0;
        end else begin
            if (accept) begin
                count_q <= count_q + 1'b1;
            end else if (ack_batch) begin
                count_q <= '0;
            end
            for (int k = 0; k < NUM; k++) begin
                if (accept && (count_q == CW'(k))) begin
                    batch_data_q[k*ITEM_WIDTH +: ITEM_WIDTH] <= bus.in_data_i;
                end
            end
        end
    end

`ifdef RES_COLLECTOR_CHECKSUM_EN
    // Running sum of the batch; wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            checksum_q <= '0;
        end else if (accept) begin
            checksum_q <= checksum_q + 16'(bus.in_data_i);
        end else if (ack_batch) begin
            checksum_q <= '0;
        end
    end

    assign bus.checksum_o = checksum_q;
`endif

    assign bus.count_o      = count_q;
    assign bus.batch_data_o = batch_data_q;

endmodule

// File: tb/tb_res_collector.sv
// ---------------------------------------------------------------------------
// tb_res_collector
//
// Self-checking bench for res_collector with NUM=4, ITEM_WIDTH=8. A batch
// model (list of accepted items, slot array, full flag, running sum) is
// advanced after every rising edge from the inputs that were applied; a
// compare process checks all DUT outputs against it on every falling edge.
// Directed scenarios add literal expectations, then a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_res_collector;

    localparam int NUM        = 4;
    localparam int ITEM_WIDTH = 8;
    localparam int CW         = $clog2(NUM + 1);

    logic clk;
    logic reset;

    res_collector_if #(.NUM(NUM), .ITEM_WIDTH(ITEM_WIDTH)) bus ();

    res_collector #(.NUM(NUM), .ITEM_WIDTH(ITEM_WIDTH)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the batch.
    logic [ITEM_WIDTH-1:0] model_items[$];
    logic [ITEM_WIDTH-1:0] model_slots[NUM];
    bit                    model_full = 1'b0;
    logic [15:0]           model_sum  = '0;
    bit                    checking   = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    function automatic logic [NUM*ITEM_WIDTH-1:0] modelBatch();
        logic [NUM*ITEM_WIDTH-1:0] b;
        b = '0;
        for (int k = 0; k < NUM; k++) b[k*ITEM_WIDTH +: ITEM_WIDTH] = model_slots[k];
        return b;
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model,
    // and return on the following falling edge.
    task automatic applyStimulus(input bit valid, input logic [ITEM_WIDTH-1:0] data,
                                 input bit flush, input bit ack, input bit rst);
        bus.in_valid_i  = valid;
        bus.in_data_i   = data;
        bus.flush_i     = flush;
        bus.batch_ack_i = ack;
        reset           = rst;
        @(posedge clk);
        if (rst) begin
            model_items.delete();
            for (int k = 0; k < NUM; k++) model_slots[k] = '0;
            model_full = 1'b0;
            model_sum  = '0;
            checking   = 1'b1;
        end else if (!model_full) begin
            if (valid) begin
                model_slots[model_items.size()] = data;
                model_items.push_back(data);
                model_sum = model_sum + 16'(data);
            end
            if (model_items.size() == NUM) model_full = 1'b1;
            else if (flush && model_items.size() > 0) model_full = 1'b1;
        end else if (ack) begin
            model_full = 1'b0;
            model_items.delete();
            model_sum = '0;
        end
        @(negedge clk);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("in_ready", 64'(bus.in_ready_o), 64'(!model_full));
            checkOutput("batch_done", 64'(bus.batch_done_o), 64'(model_full));
            checkOutput("count", 64'(bus.count_o), 64'(model_items.size()));
            checkOutput("batch_data", 64'(bus.batch_data_o), 64'(modelBatch()));
`ifdef RES_COLLECTOR_CHECKSUM_EN
            checkOutput("checksum", 64'(bus.checksum_o), 64'(model_sum));
`endif
        end
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.flush_i     = 1'b0;
        bus.batch_ack_i = 1'b0;
        reset           = 1'b1;
        @(negedge clk);

        // Reset state
        applyStimulus(0, 8'h00, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("rst_ready", 64'(bus.in_ready_o), 64'd1);
        checkOutput("rst_done", 64'(bus.batch_done_o), 64'd0);
        checkOutput("rst_count", 64'(bus.count_o), 64'd0);
        checkOutput("rst_data", 64'(bus.batch_data_o), 64'd0);

        // Full batch
        applyStimulus(1, 8'h11, 0, 0, 0);
        applyStimulus(1, 8'h22, 0, 0, 0);
        applyStimulus(1, 8'h33, 0, 0, 0);
        checkOutput("pre_full_done", 64'(bus.batch_done_o), 64'd0);
        applyStimulus(1, 8'h44, 0, 0, 0);
        checkOutput("full_done", 64'(bus.batch_done_o), 64'd1);
        checkOutput("full_count", 64'(bus.count_o), 64'd4);
        checkOutput("full_data", 64'(bus.batch_data_o), 64'h44332211);
        checkOutput("full_ready", 64'(bus.in_ready_o), 64'd0);

        // Back-pressure in FULL
        for (int i = 0; i < 3; i++) applyStimulus(1, 8'h55, 0, 0, 0);
        checkOutput("bp_count", 64'(bus.count_o), 64'd4);
        checkOutput("bp_data", 64'(bus.batch_data_o), 64'h44332211);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("ack_count", 64'(bus.count_o), 64'd0);
        checkOutput("ack_ready", 64'(bus.in_ready_o), 64'd1);
        checkOutput("ack_data_kept", 64'(bus.batch_data_o), 64'h44332211);

        // Flush with a simultaneous item
        applyStimulus(1, 8'hA1, 0, 0, 0);
        applyStimulus(1, 8'hA2, 0, 0, 0);
        applyStimulus(1, 8'hA3, 1, 0, 0);
        checkOutput("flush_done", 64'(bus.batch_done_o), 64'd1);
        checkOutput("flush_count", 64'(bus.count_o), 64'd3);
        checkOutput("flush_low24", 64'(bus.batch_data_o[23:0]), 64'hA3A2A1);
        checkOutput("flush_slot3", 64'(bus.batch_data_o[31:24]), 64'h44);
        applyStimulus(0, 8'h00, 0, 1, 0);
        applyStimulus(0, 8'h00, 1, 0, 0);
        checkOutput("empty_flush_ready", 64'(bus.in_ready_o), 64'd1);
        checkOutput("empty_flush_done", 64'(bus.batch_done_o), 64'd0);

        // Reset mid-batch
        applyStimulus(1, 8'h01, 0, 0, 0);
        applyStimulus(1, 8'h02, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 1);
        checkOutput("midrst_count", 64'(bus.count_o), 64'd0);
        checkOutput("midrst_data", 64'(bus.batch_data_o), 64'd0);
        checkOutput("midrst_done", 64'(bus.batch_done_o), 64'd0);
        applyStimulus(1, 8'hB1, 0, 0, 0);
        applyStimulus(1, 8'hB2, 0, 0, 0);
        applyStimulus(1, 8'hB3, 0, 0, 0);
        applyStimulus(1, 8'hB4, 0, 0, 0);
        checkOutput("fresh_data", 64'(bus.batch_data_o), 64'hB4B3B2B1);
        applyStimulus(0, 8'h00, 0, 1, 0);

        // Ignored ack in COLLECT, then checksum of four 0xFF items
        applyStimulus(1, 8'hC1, 0, 0, 0);
        applyStimulus(1, 8'hC2, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 0);
        checkOutput("collect_ack_count", 64'(bus.count_o), 64'd2);
        applyStimulus(0, 8'h00, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 8'hFF, 0, 0, 0);
        checkOutput("ff_count", 64'(bus.count_o), 64'd4);
`ifdef RES_COLLECTOR_CHECKSUM_EN
        checkOutput("ff_checksum", 64'(bus.checksum_o), 64'h03FC);
`endif
        applyStimulus(0, 8'h00, 0, 1, 0);
`ifdef RES_COLLECTOR_CHECKSUM_EN
        checkOutput("ack_checksum", 64'(bus.checksum_o), 64'h0000);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(99) < 70),
                          ITEM_WIDTH'($urandom),
                          ($urandom_range(99) < 10),
                          ($urandom_range(99) < 30),
                          ($urandom_range(99) < 2));
        end

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/res_collector.md
RES_COLLECTOR -- requirements
Module: res_collector

Interface
REQ-001 SHALL have parameter NUM, default 100, number of result items per batch.
REQ-002 SHALL have parameter ITEM_WIDTH, default 8, width of one result item in bits.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid_i  input  1  result item present on in_data_i.
REQ-006 SHALL have port in_data_i  input  ITEM_WIDTH  result item from the compute stage.
REQ-007 SHALL have port in_ready_o  output  1  collector can accept an item this cycle.
REQ-008 SHALL have port flush_i  input  1  close the current partial batch early.
REQ-009 SHALL have port batch_ack_i  input  1  consumer has read the completed batch.
REQ-010 SHALL have port batch_done_o  output  1  completed batch available.
REQ-011 SHALL have port batch_data_o  output  NUM*ITEM_WIDTH  packed batch; item k at bits [k*ITEM_WIDTH +: ITEM_WIDTH].
REQ-012 SHALL have port count_o  output  $clog2(NUM+1)  number of items in the current batch.

Function
REQ-013 SHALL implement two states: COLLECT and FULL.
REQ-014 In COLLECT, in_ready_o SHALL be 1; in FULL, in_ready_o SHALL be 0 and batch_done_o SHALL be 1.
REQ-015 An item SHALL be accepted only when in_valid_i=1 and in_ready_o=1. It SHALL be written to slot count_o, and count_o SHALL increment by 1 on the same edge.
REQ-016 Accepting the item that makes count_o equal NUM SHALL move the FSM to FULL. batch_done_o SHALL be 1 in the cycle after that acceptance (1-cycle latency).
REQ-017 flush_i=1 in COLLECT with count_o>0 SHALL move the FSM to FULL. count_o SHALL keep the partial count; unfilled slots SHALL keep their previous contents.
REQ-018 flush_i=1 in COLLECT with count_o=0 and no item accepted that cycle SHALL be ignored.
REQ-019 flush_i and an accepted item in the same cycle SHALL first store the item, then go to FULL with the incremented count.
REQ-020 batch_ack_i=1 in FULL SHALL move the FSM to COLLECT and set count_o to 0 on the same edge. batch_data_o SHALL be retained until slots are overwritten.
REQ-021 batch_ack_i in COLLECT SHALL be ignored; flush_i and in_valid_i in FULL SHALL be ignored. Items presented in FULL SHALL not be stored or counted.
REQ-022 count_o SHALL never exceed NUM; slot index SHALL never wrap within a batch.

Reset
REQ-023 reset_i=1 at a clock edge SHALL set the state to COLLECT, count_o=0, batch_done_o=0, in_ready_o=1 and every batch_data_o bit to 0.
REQ-024 Reset SHALL take priority over all other inputs, including mid-batch and in FULL. Any partial batch SHALL be discarded.

Configuration
REQ-025 With macro RES_COLLECTOR_CHECKSUM_EN defined, SHALL add output checksum_o (16 bits).
  - checksum_o = modulo-2^16 sum of all items accepted in the current batch, zero-extended.
  - SHALL update on the same edge as acceptance.
  - SHALL clear to 0 on reset and on batch_ack_i in FULL.
REQ-026 Without RES_COLLECTOR_CHECKSUM_EN, checksum_o and its adder SHALL be absent; all other behaviour SHALL be identical.

Verification (bench: NUM=4, ITEM_WIDTH=8)
REQ-027 Full batch: items 0x11,0x22,0x33,0x44 on 4 consecutive cycles -> batch_done_o=1 next cycle, count_o=4, batch_data_o=0x44332211, in_ready_o=0.
REQ-028 Back-pressure: in FULL drive in_valid_i=1, data 0x55 for 3 cycles -> count_o stays 4, batch_data_o unchanged; ack -> count_o=0, in_ready_o=1 next cycle.
REQ-029 Flush: accept 0xA1,0xA2, then flush_i together with 0xA3 -> FULL, count_o=3, low 24 bits of batch_data_o = 0xA3A2A1; flush_i with count_o=0 -> stays COLLECT.
REQ-030 Reset mid-batch: accept 2 items, assert reset_i one cycle -> count_o=0, batch_data_o=0, batch_done_o=0; a fresh 4-item batch then completes normally.
REQ-031 Ignored inputs: batch_ack_i pulsed in COLLECT with count_o=2 -> count_o stays 2; then 0xFF,0xFF,0xFF,0xFF with CHECKSUM_EN -> checksum_o=0x03FC, cleared to 0 after ack.
